// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the CPU it feeds: default
// widths, the halt opcode, the bubble word and the fetch-state encoding.
package cpu_pkg;

   localparam int DEFAULT_INSTR_WIDTH = 20;
   localparam int DEFAULT_PC_BITS     = 5;

   // Top nibble of a fetched word that stops the stage (halt-detect builds only)
   localparam logic [3:0] HALT_OPCODE = 4'hF;

   // Bubble word driven on a jump and after reset
   localparam logic [DEFAULT_INSTR_WIDTH-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/instr_rom.sv
// Program memory for the fetch stage: one synchronous write port used for
// loading and one registered read port used for fetching.
// IFETCH_HALT_DETECT_EN adds a combinational opcode peek at the read address
// so the top level can recognise a halt word on the edge that fetches it.
module instr_rom
   import cpu_pkg::*;
#(
   parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
   parameter int PC_BITS     = DEFAULT_PC_BITS
) (
   input  logic                   clk,
   input  logic                   wr_en_i,
   input  logic [PC_BITS-1:0]     wr_addr_i,
   input  logic [INSTR_WIDTH-1:0] wr_data_i,
   input  logic                   rd_en_i,
   input  logic                   rd_clr_i,
   input  logic [PC_BITS-1:0]     rd_addr_i,
`ifdef IFETCH_HALT_DETECT_EN
   output logic [3:0]             rd_op_o,
`endif
   output logic [INSTR_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 1 << PC_BITS;

   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
   logic [INSTR_WIDTH-1:0] rd_data_q;

   // Program load: write one word per cycle when enabled
   // NOTE: the array has no reset so it maps onto plain RAM and survives rst;
   // like every clocked block here it uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read: clear forces the bubble word, enable fetches, else hold
   always_ff @(posedge clk) begin
      if (rd_clr_i) begin
         rd_data_q <= INSTR_WIDTH'(NOP_INSTR);
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

`ifdef IFETCH_HALT_DETECT_EN
   assign rd_op_o = mem_q[rd_addr_i][INSTR_WIDTH-1 -: 4];
`endif

endmodule : instr_rom

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of simple_cpu: program counter, run-control
// FSM and the program memory. Presents one registered instruction per cycle.
// Optional feature macro: IFETCH_HALT_DETECT_EN (halt-opcode detection and
// the HALTED state); without it the PC free-runs and `halted` is tied low.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
   parameter int PC_BITS     = DEFAULT_PC_BITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   jump_en,
   input  logic [PC_BITS-1:0]     jump_addr,
   input  logic                   load_en,
   input  logic [PC_BITS-1:0]     load_addr,
   input  logic [INSTR_WIDTH-1:0] load_data,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid,
   output logic [PC_BITS-1:0]     pc,
   output logic                   halted
);

   fetch_state_t       state_q, state_d;
   logic [PC_BITS-1:0] pc_q, pc_d;
   logic               instr_valid_q, instr_valid_d;

   logic rom_wr_en;
   logic rom_rd_en;
   logic rom_rd_clr;
   logic halt_hit;

`ifdef IFETCH_HALT_DETECT_EN
   logic [3:0] rom_rd_op;
   logic       halted_q;

   // The word about to be fetched carries the halt opcode
   assign halt_hit = (rom_rd_op == HALT_OPCODE);
`else
   assign halt_hit = 1'b0;
`endif

   // Next-state, PC and memory-port control
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_valid_d = 1'b0;
      rom_wr_en     = 1'b0;
      rom_rd_en     = 1'b0;
      rom_rd_clr    = rst;

      case (state_q)
         IDLE: begin
            rom_wr_en = load_en & ~rst;
            if (start) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (jump_en) begin
               // Redirect and insert one bubble
               pc_d       = jump_addr;
               rom_rd_clr = 1'b1;
            end else if (!stall) begin
               rom_rd_en     = 1'b1;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + 1'b1;
               if (halt_hit) begin
                  state_d = HALTED;
               end
            end
         end

`ifdef IFETCH_HALT_DETECT_EN
         HALTED: begin
            // Instruction and PC stay frozen; only start leaves this state
            if (start) begin
               state_d = RUN;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, PC and valid registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

`ifdef IFETCH_HALT_DETECT_EN
   // Halted flag rises on the same edge that enters HALTED
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= (state_d == HALTED);
      end
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   instr_rom #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .PC_BITS     (PC_BITS)
   ) u_instr_rom (
      .clk       (clk),
      .wr_en_i   (rom_wr_en),
      .wr_addr_i (load_addr),
      .wr_data_i (load_data),
      .rd_en_i   (rom_rd_en),
      .rd_clr_i  (rom_rd_clr),
      .rd_addr_i (pc_q),
`ifdef IFETCH_HALT_DETECT_EN
      .rd_op_o   (rom_rd_op),
`endif
      .rd_data_o (instruction)
   );

   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. Outputs are sampled 1 ns after each
// rising edge; inputs are changed at the same point, well away from the edge.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stall;
   logic        jump_en;
   logic [4:0]  jump_addr;
   logic        load_en;
   logic [4:0]  load_addr;
   logic [19:0] load_data;
   logic [19:0] instruction;
   logic        instr_valid;
   logic [4:0]  pc;
   logic        halted;

   int n_pass  = 0;
   int n_total = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stall       (stall),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [4:0] addr, input logic [19:0] data);
      load_en   = 1'b1;
      load_addr = addr;
      load_data = data;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Start pulse plus the first fetch: afterwards mem[0] is on instruction
   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      tick();
      rst   = 1'b0;
      start = 1'b0;
      n_total++; if (pc !== 5'd0) $display("FAIL reset_pc got %0d want 0", pc); else n_pass++;
      n_total++; if (instruction !== 20'h0) $display("FAIL reset_instr got %h want 00000", instruction); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else n_pass++;
      n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
      tick();
      n_total++; if (instr_valid !== 1'b0 || pc !== 5'd0) $display("FAIL idle_hold valid=%b pc=%0d want 0/0", instr_valid, pc); else n_pass++;
   endtask

   task automatic test_load_fetch();
      load_word(5'd0,  20'h1_0203);
      load_word(5'd1,  20'h2_0405);
      load_word(5'd2,  20'h3_0607);
      load_word(5'd3,  20'hF_0000);
      load_word(5'd4,  20'h4_0809);
      load_word(5'd5,  20'h5_0A0B);
      load_word(5'd30, 20'h6_1E1E);
      load_word(5'd31, 20'h7_1F1F);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (instr_valid !== 1'b0 || pc !== 5'd0) $display("FAIL start_latency valid=%b pc=%0d want 0/0", instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h1_0203 || instr_valid !== 1'b1 || pc !== 5'd1) $display("FAIL fetch0 instr=%h valid=%b pc=%0d want 10203/1/1", instruction, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h2_0405 || instr_valid !== 1'b1 || pc !== 5'd2) $display("FAIL fetch1 instr=%h valid=%b pc=%0d want 20405/1/2", instruction, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h3_0607 || instr_valid !== 1'b1 || pc !== 5'd3) $display("FAIL fetch2 instr=%h valid=%b pc=%0d want 30607/1/3", instruction, instr_valid, pc); else n_pass++;
      do_reset();
   endtask

   task automatic test_stall();
      do_reset();
      start_run();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++; if (instruction !== 20'h1_0203 || instr_valid !== 1'b0 || pc !== 5'd1) $display("FAIL stall%0d instr=%h valid=%b pc=%0d want 10203/0/1", i, instruction, instr_valid, pc); else n_pass++;
      end
      stall = 1'b0;
      tick();
      n_total++; if (instruction !== 20'h2_0405 || instr_valid !== 1'b1 || pc !== 5'd2) $display("FAIL stall_resume instr=%h valid=%b pc=%0d want 20405/1/2", instruction, instr_valid, pc); else n_pass++;
   endtask

   task automatic test_jump_stall();
      do_reset();
      start_run();
      jump_en   = 1'b1;
      jump_addr = 5'd30;
      stall     = 1'b1;
      tick();
      jump_en   = 1'b0;
      stall     = 1'b0;
      n_total++; if (instruction !== 20'h0 || instr_valid !== 1'b0 || pc !== 5'd30) $display("FAIL jump_bubble instr=%h valid=%b pc=%0d want 00000/0/30", instruction, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h6_1E1E || instr_valid !== 1'b1 || pc !== 5'd31) $display("FAIL jump_m30 instr=%h valid=%b pc=%0d want 61E1E/1/31", instruction, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h7_1F1F || instr_valid !== 1'b1 || pc !== 5'd0) $display("FAIL jump_m31_wrap instr=%h valid=%b pc=%0d want 71F1F/1/0", instruction, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h1_0203 || instr_valid !== 1'b1 || pc !== 5'd1) $display("FAIL wrap_m0 instr=%h valid=%b pc=%0d want 10203/1/1", instruction, instr_valid, pc); else n_pass++;
   endtask

   task automatic test_halt();
      do_reset();
      start_run();
      tick();
      tick();
      tick();
      n_total++; if (instruction !== 20'hF_0000 || instr_valid !== 1'b1 || pc !== 5'd4) $display("FAIL halt_word instr=%h valid=%b pc=%0d want F0000/1/4", instruction, instr_valid, pc); else n_pass++;
`ifdef IFETCH_HALT_DETECT_EN
      n_total++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else n_pass++;
      jump_en   = 1'b1;
      jump_addr = 5'd30;
      stall     = 1'b1;
      tick();
      jump_en   = 1'b0;
      stall     = 1'b0;
      n_total++; if (instruction !== 20'hF_0000 || instr_valid !== 1'b0 || pc !== 5'd4 || halted !== 1'b1) $display("FAIL halted_hold instr=%h valid=%b pc=%0d halted=%b want F0000/0/4/1", instruction, instr_valid, pc, halted); else n_pass++;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (halted !== 1'b0 || instr_valid !== 1'b0 || pc !== 5'd4) $display("FAIL resume_edge halted=%b valid=%b pc=%0d want 0/0/4", halted, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h4_0809 || instr_valid !== 1'b1 || pc !== 5'd5) $display("FAIL resume_m4 instr=%h valid=%b pc=%0d want 40809/1/5", instruction, instr_valid, pc); else n_pass++;
`else
      n_total++; if (halted !== 1'b0) $display("FAIL halt_flag_off got %b want 0", halted); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h4_0809 || instr_valid !== 1'b1 || pc !== 5'd5) $display("FAIL through_m4 instr=%h valid=%b pc=%0d want 40809/1/5", instruction, instr_valid, pc); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h5_0A0B || instr_valid !== 1'b1 || pc !== 5'd6 || halted !== 1'b0) $display("FAIL through_m5 instr=%h valid=%b pc=%0d halted=%b want 50A0B/1/6/0", instruction, instr_valid, pc, halted); else n_pass++;
`endif
   endtask

   task automatic test_reset_midrun_load();
      do_reset();
      start_run();
      tick();
      load_en   = 1'b1;
      load_addr = 5'd0;
      load_data = 20'hA_AAAA;
      tick();
      load_en   = 1'b0;
      n_total++; if (instruction !== 20'h3_0607 || pc !== 5'd3) $display("FAIL load_in_run_fetch instr=%h pc=%0d want 30607/3", instruction, pc); else n_pass++;
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      n_total++; if (pc !== 5'd0 || instruction !== 20'h0 || instr_valid !== 1'b0 || halted !== 1'b0) $display("FAIL midrun_reset pc=%0d instr=%h valid=%b halted=%b want 0/00000/0/0", pc, instruction, instr_valid, halted); else n_pass++;
      tick();
      n_total++; if (pc !== 5'd0 || instr_valid !== 1'b0) $display("FAIL midrun_reset_idle pc=%0d valid=%b want 0/0", pc, instr_valid); else n_pass++;
      rst       = 1'b1;
      load_en   = 1'b1;
      load_addr = 5'd1;
      load_data = 20'hB_BBBB;
      tick();
      rst       = 1'b0;
      load_en   = 1'b0;
      start_run();
      n_total++; if (instruction !== 20'h1_0203) $display("FAIL mem0_kept got %h want 10203", instruction); else n_pass++;
      tick();
      n_total++; if (instruction !== 20'h2_0405) $display("FAIL mem1_reset_wins got %h want 20405", instruction); else n_pass++;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stall     = 1'b0;
      jump_en   = 1'b0;
      jump_addr = '0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;

      test_reset();
      test_load_fetch();
      test_stall();
      test_jump_stall();
      test_halt();
      test_reset_midrun_load();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_instr_fetch
